// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO pointer logic.
// Latency: none; this package holds only constants and pure functions.
// Backpressure: not applicable.
package async_fifo_pkg;

  localparam int DEFAULT_ASIZE = 4;

  // Widest pointer the helpers handle; callers size-cast the result down.
  localparam int PTR_MAX_W = 32;

  // Binary to reflected Gray. Works for any width up to PTR_MAX_W because
  // the unused upper bits stay zero.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary via a running XOR from the MSB down.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Write Gray pointer value that means "full" for a given read Gray pointer
  // of width w: the top two bits inverted, the rest equal.
  function automatic logic [PTR_MAX_W-1:0] full_pattern(input logic [PTR_MAX_W-1:0] rg,
                                                        input int unsigned w);
    return rg ^ (PTR_MAX_W'(3) << (w - 2));
  endfunction

endpackage

// File: rtl/async_fifo_wptr_full_if.sv
// Write-side status bus between the FIFO write logic and its user.
// Latency: wires only.
// Backpressure: wfull from the slave gates winc acceptance.
interface async_fifo_wptr_full_if #(parameter int ASIZE = 4);

  logic             winc;
  logic [ASIZE:0]   wq2_rptr;
  logic             ovf_clr;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             walmost_full;
  logic [ASIZE:0]   wcount;
  logic             wovf;

  // Requester side: issues writes, supplies the synchronized read pointer.
  modport master (
    output winc, wq2_rptr, ovf_clr,
    input  waddr, wptr, wfull, walmost_full, wcount, wovf
  );

  // Pointer/status generator side.
  modport slave (
    input  winc, wq2_rptr, ovf_clr,
    output waddr, wptr, wfull, walmost_full, wcount, wovf
  );

endinterface

// File: rtl/async_fifo_gray2bin.sv
// Combinational Gray-to-binary converter, shared by both FIFO domains.
// Latency: zero cycles (pure XOR prefix).
// Backpressure: none.
module async_fifo_gray2bin
  import async_fifo_pkg::*;
#(
  parameter int W = DEFAULT_ASIZE + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer, full, almost-full, fill count and overflow generator.
// Latency: all outputs registered; a write shows on wptr/wcount one edge later.
// Backpressure: winc is ignored while wfull=1 and raises the sticky wovf flag.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ASIZE    = DEFAULT_ASIZE,
  parameter int AF_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  async_fifo_wptr_full_if.slave bus
);

  localparam int PW = ASIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wlevel_next;
  logic [PW-1:0] full_pat;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wcount_q;
  logic          wen;
  logic          wfull_q;
  logic          walmost_full_q;
  logic          wovf_q;

  // Synchronized read pointer back to binary for the level arithmetic.
  async_fifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (bus.wq2_rptr),
    .bin  (rbin_s)
  );

  // Next-pointer, next-level and full-compare values for this cycle.
  always_comb begin
    wen         = bus.winc & ~wfull_q;
    wbinnext    = wbin + PW'(wen);
    wgraynext   = PW'(bin2gray(PTR_MAX_W'(wbinnext)));
    wlevel_next = wbinnext - rbin_s;
    full_pat    = PW'(full_pattern(PTR_MAX_W'(bus.wq2_rptr), PW));
  end

  // Binary and Gray write pointers advance together; Gray crosses domains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin   <= '0;
      wptr_q <= '0;
    end else begin
      wbin   <= wbinnext;
      wptr_q <= wgraynext;
    end
  end

  // Status uses the post-write pointer so full lands on the filling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wfull_q        <= 1'b0;
      wcount_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wfull_q        <= (wgraynext == full_pat);
      wcount_q       <= wlevel_next;
      walmost_full_q <= (wlevel_next >= PW'(AF_LEVEL));
    end
  end

  // Sticky overflow; a new dropped write beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wovf_q <= 1'b0;
    end else if (bus.winc & wfull_q) begin
      wovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      wovf_q <= 1'b0;
    end
  end

  assign bus.waddr        = wbin[ASIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wcount       = wcount_q;
  assign bus.wovf         = wovf_q;

endmodule
